// File: rtl/ccip_avmm_pkg.sv
// Shared definitions for the CCI-P Avalon-MM CSR slave: word map, DFH constant and write-merge helpers.
`timescale 1ns/1ps
package ccip_avmm_pkg;

    localparam int CCIP_AVMM_MMIO_ADDR_WIDTH = 18;
    localparam int CSR_DATA_W                = 64;

    localparam logic [3:0] WORD_DFH      = 4'd0;
    localparam logic [3:0] WORD_ID_L     = 4'd1;
    localparam logic [3:0] WORD_ID_H     = 4'd2;
    localparam logic [3:0] WORD_SCRATCH0 = 4'd3;
    localparam logic [3:0] WORD_SCRATCH1 = 4'd4;
    localparam logic [3:0] WORD_CTRL     = 4'd5;
    localparam logic [3:0] WORD_STATUS   = 4'd6;
    localparam logic [3:0] WORD_EVENT    = 4'd7;
    localparam logic [3:0] WORD_CYCLES   = 4'd8;

    typedef enum logic [3:0] {
        CSR_DFH      = WORD_DFH,
        CSR_ID_L     = WORD_ID_L,
        CSR_ID_H     = WORD_ID_H,
        CSR_SCRATCH0 = WORD_SCRATCH0,
        CSR_SCRATCH1 = WORD_SCRATCH1,
        CSR_CTRL     = WORD_CTRL,
        CSR_STATUS   = WORD_STATUS,
        CSR_EVENT    = WORD_EVENT,
        CSR_CYCLES   = WORD_CYCLES
    } csr_word_e;

    // {type, reserved, end-of-list, next offset, feature rev/id}
    localparam logic [63:0] CSR_DFH_VALUE = {4'h1, 19'h0, 1'b1, 24'h0, 16'h0};

    function automatic logic [63:0] be_to_mask(input logic [7:0] be);
        logic [63:0] mask;
        for (int i = 0; i < 8; i++) begin
            mask[8*i +: 8] = {8{be[i]}};
        end
        return mask;
    endfunction

    function automatic logic [63:0] csr_merge(input logic [63:0] old_v,
                                              input logic [63:0] new_v,
                                              input logic [63:0] mask);
        return (old_v & ~mask) | (new_v & mask);
    endfunction

endpackage

// File: rtl/ccip_avmm_rd_pipe.sv
// Fixed-latency read response delay line carrying {valid, data}; data is zero whenever valid is low.
`timescale 1ns/1ps
module ccip_avmm_rd_pipe #(
    parameter int READ_LATENCY = 2,
    parameter int DATA_W       = 64
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid_i,
    input  logic [DATA_W-1:0] in_data_i,
    output logic              out_valid_o,
    output logic [DATA_W-1:0] out_data_o
);

    logic [DATA_W:0] stage_q [READ_LATENCY];
    logic [DATA_W:0] stage_d;

    // Zeroing data on bubbles keeps the output quiet without an extra output mux.
    assign stage_d = in_valid_i ? {1'b1, in_data_i} : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < READ_LATENCY; i++) begin
                stage_q[i] <= '0;
            end
        end else begin
            stage_q[0] <= stage_d;
            for (int i = 1; i < READ_LATENCY; i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign {out_valid_o, out_data_o} = stage_q[READ_LATENCY-1];

endmodule

// File: rtl/ccip_avmm_csr_slave.sv
// CCI-P AFU CSR block on an Avalon-MM slave: DFH/ID, scratch, CTRL, STATUS, W1C EVENT and CYCLES.
// Define CCIP_AVMM_CSR_DFH_EN to make word 0 a constant DFH; otherwise word 0 is a third scratch.
`timescale 1ns/1ps
module ccip_avmm_csr_slave
    import ccip_avmm_pkg::*;
#(
    parameter logic [63:0] AFU_ID_L     = 64'h0,
    parameter logic [63:0] AFU_ID_H     = 64'h0,
    parameter int          READ_LATENCY = 2
) (
    input  logic                                 clk,
    input  logic                                 reset,
    input  logic [CCIP_AVMM_MMIO_ADDR_WIDTH-1:0] avs_address,
    input  logic                                 avs_read,
    input  logic                                 avs_write,
    input  logic [63:0]                          avs_writedata,
    input  logic [7:0]                           avs_byteenable,
    output logic                                 avs_waitrequest,
    output logic [63:0]                          avs_readdata,
    output logic                                 avs_readdatavalid,
    output logic [63:0]                          csr_ctrl,
    input  logic [63:0]                          csr_status,
    input  logic [63:0]                          csr_event
);

    logic        wait_q;
    logic        rd_acc, wr_acc, in_range;
    logic [3:0]  word_idx;
    logic [63:0] wmask, rd_data;
    logic [2:0]  addr_lsb_unused;

    logic [63:0] scratch0_q, scratch0_d;
    logic [63:0] scratch1_q, scratch1_d;
    logic [63:0] ctrl_q, ctrl_d;
    logic [63:0] event_q, event_d;
    logic [63:0] cycles_q, cycles_d;
`ifndef CCIP_AVMM_CSR_DFH_EN
    logic [63:0] scratch2_q, scratch2_d;
`endif

    // Held high through reset and released on the first clock edge afterwards.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) wait_q <= 1'b1;
        else       wait_q <= 1'b0;
    end

    assign avs_waitrequest = wait_q;
    assign rd_acc          = avs_read  & ~wait_q;
    assign wr_acc          = avs_write & ~wait_q;
    assign in_range        = ~|avs_address[CCIP_AVMM_MMIO_ADDR_WIDTH-1:7];
    assign word_idx        = avs_address[6:3];
    assign addr_lsb_unused = avs_address[2:0];
    assign wmask           = be_to_mask(avs_byteenable);

    always_comb begin
        scratch0_d = scratch0_q;
        scratch1_d = scratch1_q;
        ctrl_d     = ctrl_q;
        event_d    = event_q | csr_event;
        cycles_d   = cycles_q + 64'd1;
`ifndef CCIP_AVMM_CSR_DFH_EN
        scratch2_d = scratch2_q;
`endif
        if (wr_acc && in_range) begin
            case (word_idx)
`ifndef CCIP_AVMM_CSR_DFH_EN
                WORD_DFH:      scratch2_d = csr_merge(scratch2_q, avs_writedata, wmask);
`endif
                WORD_SCRATCH0: scratch0_d = csr_merge(scratch0_q, avs_writedata, wmask);
                WORD_SCRATCH1: scratch1_d = csr_merge(scratch1_q, avs_writedata, wmask);
                WORD_CTRL:     ctrl_d     = csr_merge(ctrl_q, avs_writedata, wmask);
                // Set wins over clear: the incoming pulse is ORed after the clear.
                WORD_EVENT:    event_d    = (event_q & ~(avs_writedata & wmask)) | csr_event;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scratch0_q <= '0;
            scratch1_q <= '0;
            ctrl_q     <= '0;
            event_q    <= '0;
            cycles_q   <= '0;
`ifndef CCIP_AVMM_CSR_DFH_EN
            scratch2_q <= '0;
`endif
        end else begin
            scratch0_q <= scratch0_d;
            scratch1_q <= scratch1_d;
            ctrl_q     <= ctrl_d;
            event_q    <= event_d;
            cycles_q   <= cycles_d;
`ifndef CCIP_AVMM_CSR_DFH_EN
            scratch2_q <= scratch2_d;
`endif
        end
    end

    // Reads sample current register state, so a same-cycle write is not yet visible.
    always_comb begin
        rd_data = '0;
        if (in_range) begin
            case (csr_word_e'(word_idx))
`ifdef CCIP_AVMM_CSR_DFH_EN
                CSR_DFH:      rd_data = CSR_DFH_VALUE;
`else
                CSR_DFH:      rd_data = scratch2_q;
`endif
                CSR_ID_L:     rd_data = AFU_ID_L;
                CSR_ID_H:     rd_data = AFU_ID_H;
                CSR_SCRATCH0: rd_data = scratch0_q;
                CSR_SCRATCH1: rd_data = scratch1_q;
                CSR_CTRL:     rd_data = ctrl_q;
                CSR_STATUS:   rd_data = csr_status;
                CSR_EVENT:    rd_data = event_q;
                CSR_CYCLES:   rd_data = cycles_q;
                default:      rd_data = '0;
            endcase
        end
    end

    ccip_avmm_rd_pipe #(
        .READ_LATENCY (READ_LATENCY),
        .DATA_W       (64)
    ) u_rd_pipe (
        .clk         (clk),
        .reset       (reset),
        .in_valid_i  (rd_acc),
        .in_data_i   (rd_data),
        .out_valid_o (avs_readdatavalid),
        .out_data_o  (avs_readdata)
    );

    assign csr_ctrl = ctrl_q;

endmodule

// File: tb/tb_ccip_avmm_csr_slave.sv
// Scoreboard bench for ccip_avmm_csr_slave: reads push expected data, a monitor pops on readdatavalid.
`timescale 1ns/1ps
module tb_ccip_avmm_csr_slave;
    import ccip_avmm_pkg::*;

    localparam int          LAT  = 2;
    localparam logic [63:0] ID_L = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;
    localparam logic [63:0] STAT = 64'h0123_0000_ABCD_5555;

    logic                                 clk = 1'b0;
    logic                                 reset = 1'b1;
    logic [CCIP_AVMM_MMIO_ADDR_WIDTH-1:0] avs_address = '0;
    logic                                 avs_read = 1'b0;
    logic                                 avs_write = 1'b0;
    logic [63:0]                          avs_writedata = '0;
    logic [7:0]                           avs_byteenable = '0;
    logic                                 avs_waitrequest;
    logic [63:0]                          avs_readdata;
    logic                                 avs_readdatavalid;
    logic [63:0]                          csr_ctrl;
    logic [63:0]                          csr_status = STAT;
    logic [63:0]                          csr_event = '0;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    logic [63:0] tb_cycles;

    typedef struct {
        logic [63:0] data;
        int          acc;
    } exp_t;
    exp_t sb_q[$];
    exp_t e;

    ccip_avmm_csr_slave #(
        .AFU_ID_L     (ID_L),
        .AFU_ID_H     (ID_H),
        .READ_LATENCY (LAT)
    ) dut (
        .clk               (clk),
        .reset             (reset),
        .avs_address       (avs_address),
        .avs_read          (avs_read),
        .avs_write         (avs_write),
        .avs_writedata     (avs_writedata),
        .avs_byteenable    (avs_byteenable),
        .avs_waitrequest   (avs_waitrequest),
        .avs_readdata      (avs_readdata),
        .avs_readdatavalid (avs_readdatavalid),
        .csr_ctrl          (csr_ctrl),
        .csr_status        (csr_status),
        .csr_event         (csr_event)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    // Reference free-running counter: zero in reset, +1 per clock otherwise.
    always @(posedge clk or posedge reset) begin
        if (reset) tb_cycles <= '0;
        else       tb_cycles <= tb_cycles + 64'd1;
    end

    always @(negedge clk) begin
        if (!reset) begin
            if (avs_readdatavalid) begin
                checks++;
                if (sb_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_rdv: got readdatavalid=1 data=%h, required no response", avs_readdata);
                end else begin
                    e = sb_q.pop_front();
                    if (avs_readdata !== e.data) begin
                        errors++;
                        $display("FAIL rd_data: got %h, required %h", avs_readdata, e.data);
                    end
                    checks++;
                    if (cyc - e.acc != LAT) begin
                        errors++;
                        $display("FAIL rd_latency: got %0d, required %0d", cyc - e.acc, LAT);
                    end
                end
            end else begin
                checks++;
                if (avs_readdata !== 64'h0) begin
                    errors++;
                    $display("FAIL rdata_idle: got %h, required 0", avs_readdata);
                end
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog");
    end

    task automatic wait_ready();
        int n = 0;
        while (avs_waitrequest !== 1'b0 && n < 20) begin
            @(negedge clk);
            n++;
        end
        if (n >= 20) begin
            checks++;
            errors++;
            $display("FAIL wait_ready: got waitrequest=%b, required 0 within 20 cycles", avs_waitrequest);
        end
    endtask

    task automatic rd(input logic [CCIP_AVMM_MMIO_ADDR_WIDTH-1:0] a, input logic [63:0] exp_d);
        wait_ready();
        avs_address    = a;
        avs_read       = 1'b1;
        avs_write      = 1'b0;
        avs_byteenable = 8'h00;
        sb_q.push_back('{data: exp_d, acc: cyc});
        @(negedge clk);
        avs_read = 1'b0;
    endtask

    task automatic wr(input logic [CCIP_AVMM_MMIO_ADDR_WIDTH-1:0] a, input logic [63:0] d,
                      input logic [7:0] be);
        wait_ready();
        avs_address    = a;
        avs_write      = 1'b1;
        avs_read       = 1'b0;
        avs_writedata  = d;
        avs_byteenable = be;
        @(negedge clk);
        avs_write = 1'b0;
    endtask

    task automatic release_reset_and_check(input string tag);
        @(posedge clk);
        #1 reset = 1'b0;
        checks++;
        if (avs_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait_release: got %b, required 1", tag, avs_waitrequest);
        end
        @(negedge clk);
        checks++;
        if (avs_waitrequest !== 1'b1) begin
            errors++;
            $display("FAIL %s_wait_half: got %b, required 1", tag, avs_waitrequest);
        end
        @(posedge clk);
        #1;
        checks++;
        if (avs_waitrequest !== 1'b0) begin
            errors++;
            $display("FAIL %s_wait_after: got %b, required 0", tag, avs_waitrequest);
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clk);
        checks++;
        if (avs_waitrequest !== 1'b1 || avs_readdatavalid !== 1'b0 ||
            avs_readdata !== 64'h0 || csr_ctrl !== 64'h0) begin
            errors++;
            $display("FAIL reset_outputs: got wr=%b rdv=%b rd=%h ctrl=%h, required 1 0 0 0",
                     avs_waitrequest, avs_readdatavalid, avs_readdata, csr_ctrl);
        end
        release_reset_and_check("reset");
        rd('h018, 64'h0);
        rd('h020, 64'h0);
        rd('h028, 64'h0);
        rd('h038, 64'h0);
`ifndef CCIP_AVMM_CSR_DFH_EN
        rd('h000, 64'h0);
`endif
    endtask

    task automatic test_scratch();
        wr('h018, 64'hDEADBEEF_CAFEF00D, 8'hFF);
        rd('h018, 64'hDEADBEEF_CAFEF00D);
        wr('h020, 64'hAAAAAAAA_AAAAAAAA, 8'hFF);
        wr('h020, 64'h11223344_55667788, 8'hA5);
        rd('h020, 64'h11AA33AA_AA66AA88);
    endtask

    task automatic test_ctrl();
        wr('h028, 64'hFFFFFFFF_FFFFFFFF, 8'h0F);
        checks++;
        if (csr_ctrl !== 64'h00000000_FFFFFFFF) begin
            errors++;
            $display("FAIL ctrl_be: got %h, required 00000000ffffffff", csr_ctrl);
        end
        rd('h028, 64'h00000000_FFFFFFFF);
    endtask

    task automatic test_event();
        csr_event = 64'h5;
        wr('h038, 64'h1, 8'hFF);
        csr_event = 64'h0;
        rd('h038, 64'h5);
        wr('h038, 64'h1, 8'hFF);
        rd('h038, 64'h4);
        wr('h038, 64'h4, 8'h00);
        rd('h038, 64'h4);
        wr('h038, 64'h4, 8'h01);
        rd('h038, 64'h0);
    endtask

    task automatic test_ro_and_reserved();
        rd('h048, 64'h0);
        rd('h400, 64'h0);
        wr('h008, 64'h1234, 8'hFF);
        rd('h008, ID_L);
        wr('h010, 64'h5678, 8'hFF);
        rd('h010, ID_H);
        wr('h030, 64'h9999, 8'hFF);
        rd('h030, STAT);
        wr('h418, 64'h0, 8'hFF);
        rd('h018, 64'hDEADBEEF_CAFEF00D);
        rd('h078, 64'h0);
    endtask

    task automatic test_rw_same_cycle();
        wait_ready();
        avs_address    = 'h020;
        avs_read       = 1'b1;
        avs_write      = 1'b1;
        avs_writedata  = 64'h0BAD_F00D_0000_0001;
        avs_byteenable = 8'hFF;
        sb_q.push_back('{data: 64'h11AA33AA_AA66AA88, acc: cyc});
        @(negedge clk);
        avs_read  = 1'b0;
        avs_write = 1'b0;
        rd('h020, 64'h0BAD_F00D_0000_0001);
    endtask

    task automatic test_cycles();
        rd('h040, tb_cycles);
        rd('h040, tb_cycles);
        repeat (5) @(negedge clk);
        rd('h040, tb_cycles);
    endtask

    task automatic test_word0();
`ifdef CCIP_AVMM_CSR_DFH_EN
        rd('h000, 64'h1000_0100_0000_0000);
        wr('h000, 64'h1234_5678_9ABC_DEF0, 8'hFF);
        rd('h000, 64'h1000_0100_0000_0000);
`else
        wr('h000, 64'h1234_5678_9ABC_DEF0, 8'hFF);
        rd('h000, 64'h1234_5678_9ABC_DEF0);
`endif
    endtask

    task automatic test_reset_inflight();
        int pulses = 0;
        wait_ready();
        avs_address    = 'h018;
        avs_read       = 1'b1;
        avs_write      = 1'b0;
        avs_byteenable = 8'h00;
        // Only the first read can complete before reset lands; the later two must vanish.
        sb_q.push_back('{data: 64'hDEADBEEF_CAFEF00D, acc: cyc});
        repeat (2) @(negedge clk);
        @(posedge clk);
        #1 reset = 1'b1;
        avs_read = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            if (avs_readdatavalid) pulses++;
            checks++;
            if (avs_waitrequest !== 1'b1) begin
                errors++;
                $display("FAIL inflight_wait: got %b, required 1", avs_waitrequest);
            end
        end
        release_reset_and_check("inflight");
        for (int i = 0; i < 2 * LAT + 2; i++) begin
            if (avs_readdatavalid) pulses++;
            @(negedge clk);
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL inflight_discard: got %0d pulses, required 0", pulses);
        end
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL inflight_first: got %0d pending, required 0", sb_q.size());
        end
        rd('h018, 64'h0);
    endtask

    initial begin
        test_reset();
        test_scratch();
        test_ctrl();
        test_event();
        test_ro_and_reserved();
        test_rw_same_cycle();
        test_cycles();
        test_word0();
        repeat (LAT + 2) @(negedge clk);
        test_reset_inflight();
        repeat (LAT + 2) @(negedge clk);
        checks++;
        if (sb_q.size() != 0) begin
            errors++;
            $display("FAIL drain: got %0d pending responses, required 0", sb_q.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
